// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM/CHR bus arbiter: render fetch priority, CPU $2007 slot, read buffer, palette redirect.
// Optional starvation guard enabled by defining PPU_ARB_STARVE_EN.
module ppu_vram_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rend_req,
  input  logic [ADDR_W-1:0] rend_addr,
  output logic              rend_stall,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [4:0]        pal_addr,
  output logic              pal_we,
  input  logic [DATA_W-1:0] pal_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PAL_MASK = ADDR_W'(14'h2FFF);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                starved;
  logic                cpu_slot;
  logic                pal_range;

`ifdef PPU_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Counter holds the number of WAIT cycles already spent; the current one makes it LIMIT.
  assign starved = (starve_q >= CNT_W'(STARVE_LIMIT - 1));

  always_comb begin
    starve_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) begin
      starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_starve;
  assign unused_starve = (STARVE_LIMIT != 0);
  assign starved       = 1'b0;
`endif

  assign cpu_slot  = (state_q == S_ADDR) || (state_q == S_DATA);
  assign pal_range = (addr_q[13:8] == 6'h3F);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = rend_req ? S_WAIT : S_ADDR;
        end
      end
      S_WAIT: begin
        if (!rend_req || starved) state_d = S_ADDR;
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        state_d = S_IDLE;
        ack_d   = 1'b1;
        // Palette reads bypass the buffer, but the buffer still loads the nametable byte underneath.
        if (!we_q) begin
          rdata_d = pal_range ? pal_rdata : buf_q;
          buf_d   = vram_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- control and architecturally visible registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // ---- latched request fields ----
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    vram_addr = rend_addr;
    if (cpu_slot) vram_addr = pal_range ? (addr_q & PAL_MASK) : addr_q;
  end

  // $3F10/14/18/1C alias the backdrop entries $3F00/04/08/0C.
  assign pal_addr   = {addr_q[4] & (addr_q[1:0] != 2'b00), addr_q[3:0]};
  assign vram_we    = (state_q == S_ADDR) && we_q && !pal_range;
  assign pal_we     = (state_q == S_ADDR) && we_q && pal_range;
  assign vram_wdata = wdata_q;
  assign rend_stall = rend_req && cpu_slot;
  assign cpu_busy   = (state_q != S_IDLE);
  assign cpu_ack    = ack_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: memory environment plus a transaction-level reference model.
module tb_ppu_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          rend_req;
  logic [AW-1:0] rend_addr;
  logic          rend_stall;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic          vram_we;
  logic [DW-1:0] vram_rdata;
  logic [4:0]    pal_addr;
  logic          pal_we;
  logic [DW-1:0] pal_rdata;

  always #5 clock = ~clock;

  ppu_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .rend_req(rend_req), .rend_addr(rend_addr), .rend_stall(rend_stall),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata),
    .pal_addr(pal_addr), .pal_we(pal_we), .pal_rdata(pal_rdata)
  );

  // Memory environment: synchronous VRAM read, combinational palette RAM.
  logic [7:0] vmem [0:16383];
  logic [7:0] pmem [0:31];
  logic       mem_init;

  function automatic logic [7:0] vinit(int i);
    return 8'((i * 37) ^ (i >> 6));
  endfunction

  function automatic logic [7:0] pinit(int i);
    return 8'(i * 11 + 3);
  endfunction

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) vmem[i] <= vinit(i);
      for (int j = 0; j < 32; j++) pmem[j] <= pinit(j);
    end else begin
      if (vram_we) vmem[vram_addr] <= vram_wdata;
      if (pal_we) pmem[pal_addr] <= vram_wdata;
      vram_rdata <= vmem[vram_addr];
    end
  end

  assign pal_rdata = pmem[pal_addr];

  // Reference model state
  logic [7:0] exp_vram [0:16383];
  logic [7:0] exp_pal  [0:31];
  logic [7:0] exp_buf;
  logic [7:0] exp_rdata;
  bit         pending_ack;
  int         total;
  int         bad;

  function automatic bit is_pal(logic [13:0] a);
    return a >= 14'h3F00;
  endfunction

  function automatic logic [13:0] bus_addr(logic [13:0] a);
    return is_pal(a) ? a - 14'h1000 : a;
  endfunction

  function automatic int pal_index(logic [13:0] a);
    int idx;
    idx = int'(a) % 32;
    if (idx >= 16 && idx % 4 == 0) idx -= 16;
    return idx;
  endfunction

  function automatic int eff_wait(int w);
`ifdef PPU_ARB_STARVE_EN
    return (w < SL) ? w : SL;
`else
    return w;
`endif
  endfunction

  task automatic model_reset();
    exp_buf     = 8'h00;
    exp_rdata   = 8'h00;
    pending_ack = 1'b0;
  endtask

  task automatic drive_idle(input int rr);
    @(posedge clock); #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 14'($urandom);
    cpu_wdata = 8'($urandom);
    rend_req  = (rr < 0) ? 1'($urandom_range(0, 1)) : 1'(rr);
    rend_addr = 14'($urandom);
    #1;
    total++; if (cpu_ack !== pending_ack) begin bad++; $display("FAIL idle_ack got=%b want=%b", cpu_ack, pending_ack); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", cpu_busy); end
    total++; if (rend_stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", rend_stall); end
    total++; if (vram_addr !== rend_addr) begin bad++; $display("FAIL idle_vaddr got=%h want=%h", vram_addr, rend_addr); end
    total++; if (vram_we !== 1'b0 || pal_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%b%b want=00", vram_we, pal_we); end
    total++; if (cpu_rdata !== exp_rdata) begin bad++; $display("FAIL idle_rdata got=%h want=%h", cpu_rdata, exp_rdata); end
    pending_ack = 1'b0;
  endtask

  // One CPU access; rend_req held high for the first w cycles (request cycle included).
  task automatic do_access(input logic we, input logic [13:0] addr, input logic [7:0] wdata, input int w);
    int          a;
    bit          pal;
    bit          slot;
    logic [13:0] ba;
    int          pidx;
    a    = 1 + eff_wait(w);
    pal  = is_pal(addr);
    ba   = bus_addr(addr);
    pidx = pal_index(addr);
    for (int t = 0; t <= a + 1; t++) begin
      @(posedge clock); #1;
      rend_addr = 14'($urandom);
      if (t < w) rend_req = 1'b1;
      else if (t == w) rend_req = 1'b0;
      else rend_req = 1'($urandom_range(0, 1));
      if (t == 0) begin
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end else begin
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 14'($urandom);
        cpu_wdata = 8'($urandom);
      end
      #1;
      slot = (t == a) || (t == a + 1);
      total++; if (cpu_ack !== ((t == 0) ? pending_ack : 1'b0)) begin bad++; $display("FAIL acc_ack t=%0d got=%b", t, cpu_ack); end
      total++; if (cpu_busy !== (t != 0)) begin bad++; $display("FAIL acc_busy t=%0d got=%b want=%b", t, cpu_busy, t != 0); end
      total++; if (vram_addr !== (slot ? ba : rend_addr)) begin bad++; $display("FAIL acc_vaddr t=%0d got=%h want=%h", t, vram_addr, slot ? ba : rend_addr); end
      total++; if (vram_we !== (t == a && we && !pal)) begin bad++; $display("FAIL acc_vram_we t=%0d got=%b", t, vram_we); end
      total++; if (pal_we !== (t == a && we && pal)) begin bad++; $display("FAIL acc_pal_we t=%0d got=%b", t, pal_we); end
      total++; if (rend_stall !== (slot && rend_req)) begin bad++; $display("FAIL acc_stall t=%0d got=%b want=%b", t, rend_stall, slot && rend_req); end
      total++; if (cpu_rdata !== exp_rdata) begin bad++; $display("FAIL acc_rdata_hold t=%0d got=%h want=%h", t, cpu_rdata, exp_rdata); end
      if (t == a && we) begin
        total++; if (vram_wdata !== wdata) begin bad++; $display("FAIL acc_wdata got=%h want=%h", vram_wdata, wdata); end
      end
      if (t == a && pal) begin
        total++; if (pal_addr !== 5'(pidx)) begin bad++; $display("FAIL acc_pal_addr got=%h want=%h", pal_addr, 5'(pidx)); end
      end
      if (t == 0) pending_ack = 1'b0;
    end
    if (we) begin
      if (pal) exp_pal[pidx] = wdata;
      else exp_vram[addr] = wdata;
    end else begin
      exp_rdata = pal ? exp_pal[pidx] : exp_buf;
      exp_buf   = exp_vram[ba];
    end
    pending_ack = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(posedge clock); #1;
      rend_req = 1'b1; rend_addr = 14'($urandom); cpu_req = 1'b1; cpu_we = 1'b1;
      #1;
      total++; if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_busy_ack got=%b%b want=00", cpu_busy, cpu_ack); end
      total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", cpu_rdata); end
      total++; if (vram_we !== 1'b0 || pal_we !== 1'b0 || rend_stall !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b%b want=000", vram_we, pal_we, rend_stall); end
      total++; if (vram_addr !== rend_addr) begin bad++; $display("FAIL rst_vaddr got=%h want=%h", vram_addr, rend_addr); end
    end
    @(posedge clock); #1;
    reset = 1'b0; cpu_req = 1'b0; rend_req = 1'b0;
    model_reset();
    drive_idle(-1);
  endtask

  task automatic test_write_basic();
    do_access(1'b1, 14'h2005, 8'hA5, 0);
    drive_idle(0);
  endtask

  task automatic test_read_buffer();
    do_access(1'b0, 14'h2005, 8'h00, 0);
    do_access(1'b0, 14'h2005, 8'h00, 0);
    drive_idle(0);
  endtask

  task automatic test_palette();
    do_access(1'b1, 14'h3F10, 8'h21, 0);
    do_access(1'b0, 14'h3F00, 8'h00, 0);
    do_access(1'b1, 14'h3F07, 8'h3C, 0);
    do_access(1'b0, 14'h3F27, 8'h00, 0);
    drive_idle(0);
  endtask

  task automatic test_render_wait();
    drive_idle(1);
    drive_idle(1);
    do_access(1'b0, 14'h0123, 8'h00, 18);
    drive_idle(0);
  endtask

`ifdef PPU_ARB_STARVE_EN
  task automatic test_starve();
    do_access(1'b0, 14'h0456, 8'h00, 40);
    do_access(1'b1, 14'h0456, 8'h77, 2);
    do_access(1'b0, 14'h0456, 8'h00, 40);
    drive_idle(1);
  endtask
`endif

  task automatic test_back_to_back();
    do_access(1'b1, 14'h1000, 8'h11, 0);
    do_access(1'b1, 14'h1001, 8'h22, 1);
    do_access(1'b0, 14'h1000, 8'h00, 0);
    do_access(1'b0, 14'h1001, 8'h00, 0);
    do_access(1'b0, 14'h1000, 8'h00, 3);
    drive_idle(0);
  endtask

  task automatic test_random();
    logic [13:0] addr;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: addr = 14'h3F00 | 14'($urandom_range(0, 255));
        1: addr = 14'h2F00 | 14'($urandom_range(0, 31));
        2: addr = 14'h2000 | 14'($urandom_range(0, 15));
        default: addr = 14'($urandom_range(0, 16'h3EFF));
      endcase
      if ($urandom_range(0, 2) == 0) drive_idle(-1);
      do_access(1'($urandom_range(0, 1)), addr, 8'($urandom),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)));
    end
    drive_idle(0);
  endtask

  task automatic test_reset_abort();
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0155; cpu_wdata = 8'h5A; rend_req = 1'b0;
    #1;
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL abort_req_busy got=%b want=0", cpu_busy); end
    @(posedge clock); #1;
    cpu_req = 1'b0;
    #1;
    total++; if (vram_we !== 1'b1) begin bad++; $display("FAIL abort_addr_we got=%b want=1", vram_we); end
    reset = 1'b1;
    #1;
    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL abort_we_drop got=%b want=0", vram_we); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", cpu_busy); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b want=0", cpu_ack); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    #1;
    total++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin bad++; $display("FAIL abort_post got=%b%b want=00", cpu_ack, cpu_busy); end
    drive_idle(0);
    drive_idle(0);
    do_access(1'b0, 14'h0155, 8'h00, 0);
    do_access(1'b0, 14'h0155, 8'h00, 0);
    drive_idle(0);
  endtask

  initial begin
    reset     = 1'b1;
    mem_init  = 1'b1;
    rend_req  = 1'b0;
    rend_addr = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    total     = 0;
    bad       = 0;
    for (int i = 0; i < 16384; i++) exp_vram[i] = vinit(i);
    for (int j = 0; j < 32; j++) exp_pal[j] = pinit(j);
    model_reset();
    @(posedge clock); #1;
    mem_init = 1'b0;

    test_reset();
    test_write_basic();
    test_read_buffer();
    test_palette();
    test_render_wait();
`ifdef PPU_ARB_STARVE_EN
    test_starve();
`endif
    test_back_to_back();
    test_random();
    test_reset_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
